config_readback: RTL and testbench

- Readback side of the configuration scan chain: the UART command decoder drives bits into the chain head, and this block captures the bits leaving the chain tail.
- Samples SHIFT_TAIL on every SHIFT_ENABLE cycle and packs the bits LSB-first into bytes.
- Buffers the bytes in a small FIFO and hands them to the UART transmitter through its ready/strobe interface, so the host can verify or dump the loaded bitstream.

---
 rtl/config_readback.sv | 144 ++++++++++++++
 tb/tb_config_readback.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/config_readback.sv
// Scan-chain readback: packs tail bits LSB-first into bytes, buffers them and strobes them to the UART.
// Optional READBACK_CHECKSUM_EN appends an XOR checksum byte after every FLUSH.
module config_readback #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned AW         = 4
) (
  input  logic        SCLK,
  input  logic        RESET,
  input  logic        SHIFT_ENABLE,
  input  logic        SHIFT_TAIL,
  input  logic        FLUSH,
  input  logic        UART_READY,
  output logic        TX_VALID,
  output logic [7:0]  TX_DATA,
  output logic        BUSY,
  output logic        OVERFLOW,
  output logic [15:0] BYTES_SENT
);

  typedef enum logic [1:0] {StIdle, StStrobe, StHold} tx_state_e;

  logic [7:0]  sreg_q, sreg_d, shifted;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [3:0]  cnt_eff;
  logic        wr_req, wr_ok, pop, full, empty;
  logic [7:0]  wr_data;
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wptr_q, rptr_q, count;
  tx_state_e   state_q, state_d;
  logic [7:0]  tx_data_q;
  logic        overflow_q;
  logic [15:0] sent_q;

`ifdef READBACK_CHECKSUM_EN
  logic [7:0] chk_q, chk_d;
  logic       chk_pend_q;
`endif

  // This cycle's bit is folded in before deciding between a full byte and a padded flush byte.
  always_comb begin
    shifted = sreg_q;
    cnt_eff = {1'b0, bitcnt_q};
    if (SHIFT_ENABLE) begin
      shifted = {SHIFT_TAIL, sreg_q[7:1]};
      cnt_eff = cnt_eff + 4'd1;
    end
    sreg_d   = shifted;
    bitcnt_d = cnt_eff[2:0];
    wr_req   = 1'b0;
    wr_data  = shifted;
    if (cnt_eff[3]) begin
      wr_req   = 1'b1;
      sreg_d   = 8'h00;
      bitcnt_d = 3'd0;
    end else if (FLUSH && cnt_eff != 4'd0) begin
      wr_req   = 1'b1;
      wr_data  = shifted >> (4'd8 - cnt_eff);
      sreg_d   = 8'h00;
      bitcnt_d = 3'd0;
`ifdef READBACK_CHECKSUM_EN
    end else if (chk_pend_q) begin
      // Bit counter is zero after a flush, so no data byte can compete for this slot.
      wr_req  = 1'b1;
      wr_data = chk_q;
`endif
    end
  end

`ifdef READBACK_CHECKSUM_EN
  always_comb begin
    chk_d = chk_q;
    if (chk_pend_q) chk_d = 8'h00;
    else if (wr_ok) chk_d = chk_q ^ wr_data;
  end
`endif

  assign count = wptr_q - rptr_q;
  assign full  = (count == (AW + 1)'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign pop   = (state_q == StStrobe);
  assign wr_ok = wr_req && (!full || pop);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (!empty && UART_READY) state_d = StStrobe;
      StStrobe: state_d = StHold;
      StHold:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Head is latched into TX_DATA on entry to STROBE, so a write into the freed slot is safe.
  always_ff @(posedge SCLK) begin
    if (wr_ok) mem[wptr_q[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge SCLK or posedge RESET) begin
    if (RESET) begin
      sreg_q     <= 8'h00;
      bitcnt_q   <= 3'd0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      state_q    <= StIdle;
      tx_data_q  <= 8'h00;
      overflow_q <= 1'b0;
      sent_q     <= 16'h0000;
    end else begin
      sreg_q   <= sreg_d;
      bitcnt_q <= bitcnt_d;
      state_q  <= state_d;
      if (wr_ok) wptr_q <= wptr_q + 1'b1;
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
        sent_q <= sent_q + 16'd1;
      end
      if (wr_req && !wr_ok) overflow_q <= 1'b1;
      if (state_q == StIdle && state_d == StStrobe) tx_data_q <= mem[rptr_q[AW-1:0]];
    end
  end

`ifdef READBACK_CHECKSUM_EN
  always_ff @(posedge SCLK or posedge RESET) begin
    if (RESET) begin
      chk_q      <= 8'h00;
      chk_pend_q <= 1'b0;
    end else begin
      chk_q      <= chk_d;
      chk_pend_q <= FLUSH;
    end
  end
`endif

  assign TX_VALID   = (state_q == StStrobe);
  assign TX_DATA    = tx_data_q;
  assign OVERFLOW   = overflow_q;
  assign BYTES_SENT = sent_q;
`ifdef READBACK_CHECKSUM_EN
  assign BUSY = !empty || (bitcnt_q != 3'd0) || (state_q != StIdle) || chk_pend_q;
`else
  assign BUSY = !empty || (bitcnt_q != 3'd0) || (state_q != StIdle);
`endif

endmodule

// File: tb/tb_config_readback.sv
// Bench for config_readback: directed and random bit streams checked against a bit-queue model.
module tb_config_readback;
  logic        SCLK = 1'b0;
  logic        RESET, SHIFT_ENABLE, SHIFT_TAIL, FLUSH, UART_READY;
  logic        TX_VALID, BUSY, OVERFLOW;
  logic [7:0]  TX_DATA;
  logic [15:0] BYTES_SENT;

  int         n_checks = 0;
  int         n_pass = 0;
  logic [7:0] got_q[$];
  int         stamp_q[$];
  int         cyc = 0;
  logic [7:0] exp_q[$];
  int         pend_bits[$];
  logic [7:0] run_xor = 8'h00;
  int         rd = 0;
  int         sent_model = 0;

  config_readback dut (
    .SCLK(SCLK), .RESET(RESET), .SHIFT_ENABLE(SHIFT_ENABLE), .SHIFT_TAIL(SHIFT_TAIL),
    .FLUSH(FLUSH), .UART_READY(UART_READY), .TX_VALID(TX_VALID), .TX_DATA(TX_DATA),
    .BUSY(BUSY), .OVERFLOW(OVERFLOW), .BYTES_SENT(BYTES_SENT)
  );

  always #5 SCLK = ~SCLK;

  always @(negedge SCLK) begin
    cyc = cyc + 1;
    if (TX_VALID) begin
      got_q.push_back(TX_DATA);
      stamp_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge SCLK);
    #1;
  endtask

  function automatic void model_push(logic [7:0] b);
    exp_q.push_back(b);
    run_xor = run_xor ^ b;
  endfunction

  // Bit i of the queue (oldest first) becomes bit i of the byte.
  function automatic logic [7:0] pack_bits();
    logic [7:0] v = 8'h00;
    for (int i = 0; i < pend_bits.size(); i++) v = v | (8'(pend_bits[i] & 1) << i);
    pend_bits.delete();
    return v;
  endfunction

  function automatic void model_bit(logic b);
    pend_bits.push_back(int'(b));
    if (pend_bits.size() == 8) model_push(pack_bits());
  endfunction

  function automatic void model_flush();
    if (pend_bits.size() > 0) model_push(pack_bits());
`ifdef READBACK_CHECKSUM_EN
    exp_q.push_back(run_xor);
    run_xor = 8'h00;
`endif
  endfunction

  task automatic do_cycle(input logic se, input logic b, input logic fl);
    SHIFT_ENABLE = se;
    SHIFT_TAIL   = b;
    FLUSH        = fl;
    step();
    SHIFT_ENABLE = 1'b0;
    FLUSH        = 1'b0;
    if (se) model_bit(b);
    if (fl) model_flush();
  endtask

  task automatic shift_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) do_cycle(1'b1, v[i], 1'b0);
  endtask

  task automatic drain(input string tag);
    int budget = 3000;
    int n_exp = exp_q.size();
    logic [7:0] e;
    while ((got_q.size() - rd) < n_exp && budget > 0) begin
      step();
      budget--;
    end
    repeat (8) step();
    check({tag, "_count"}, got_q.size() - rd, n_exp);
    sent_model += n_exp;
    while (exp_q.size() > 0 && rd < got_q.size()) begin
      e = exp_q.pop_front();
      check(tag, 32'(got_q[rd]), 32'(e));
      rd++;
    end
    exp_q.delete();
    rd = got_q.size();
    check({tag, "_bytes_sent"}, 32'(BYTES_SENT), 32'(sent_model[15:0]));
  endtask

  initial begin
    int bits1[16] = '{1, 0, 1, 0, 0, 1, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    int r0, min_gap, budget, n_seen;
    logic se, fl, last_fl;
    RESET = 1'b1; SHIFT_ENABLE = 1'b0; SHIFT_TAIL = 1'b0; FLUSH = 1'b0; UART_READY = 1'b1;
    step(); step();
    check("rst_tx_valid", 32'(TX_VALID), 0);
    check("rst_tx_data", 32'(TX_DATA), 0);
    check("rst_busy", 32'(BUSY), 0);
    check("rst_overflow", 32'(OVERFLOW), 0);
    check("rst_bytes_sent", 32'(BYTES_SENT), 0);
    RESET = 1'b0;
    step();

    // Two back-to-back bytes, with the first-byte latency observed directly.
    r0 = rd;
    for (int i = 0; i < 8; i++) do_cycle(1'b1, bits1[i][0], 1'b0);
    check("latency_not_yet", 32'(TX_VALID), 0);
    do_cycle(1'b1, bits1[8][0], 1'b0);
    check("latency_strobe", 32'(TX_VALID), 1);
    check("latency_data", 32'(TX_DATA), 32'h a5);
    for (int i = 9; i < 16; i++) do_cycle(1'b1, bits1[i][0], 1'b0);
    drain("pair");
    if (got_q.size() > r0 + 1) check("pair_gap_ge3", 32'(stamp_q[r0 + 1] - stamp_q[r0] >= 3), 1);

    // Partial byte flush, then an empty flush.
    do_cycle(1'b1, 1'b1, 1'b0);
    do_cycle(1'b1, 1'b1, 1'b0);
    do_cycle(1'b1, 1'b0, 1'b0);
    do_cycle(1'b0, 1'b0, 1'b1);
    repeat (3) step();
    do_cycle(1'b0, 1'b0, 1'b1);
    drain("flush");
    check("flush_idle_busy", 32'(BUSY), 0);

    // Flush coinciding with the 8th bit.
    for (int i = 0; i < 7; i++) do_cycle(1'b1, 1'b1, 1'b0);
    do_cycle(1'b1, 1'b1, 1'b1);
    drain("flush_8th");

`ifdef READBACK_CHECKSUM_EN
    shift_byte(8'h12);
    shift_byte(8'h34);
    do_cycle(1'b0, 1'b0, 1'b1);
    drain("checksum");
`endif

    // Random shifting, flushing and UART back-pressure.
    last_fl = 1'b0;
    for (int i = 0; i < 400; i++) begin
      se = ($urandom % 10) < 7;
      fl = (($urandom % 20) == 0) && !last_fl;
      UART_READY = ($urandom % 4) != 0;
      do_cycle(se, 1'($urandom), fl);
      last_fl = fl;
    end
    UART_READY = 1'b1;
    step();
    do_cycle(1'b0, 1'b0, 1'b1);
    drain("random");
    check("random_no_overflow", 32'(OVERFLOW), 0);

    // Fill the FIFO with UART stalled; the 17th byte is dropped.
    UART_READY = 1'b0;
    step();
    for (int i = 0; i < 16; i++) shift_byte(8'($urandom));
    check("full_no_overflow_yet", 32'(OVERFLOW), 0);
    shift_byte(8'($urandom));
    void'(exp_q.pop_back());
    check("ovf_set", 32'(OVERFLOW), 1);
    check("ovf_busy", 32'(BUSY), 1);
    check("ovf_no_strobe", got_q.size() - rd, 0);
    r0 = rd;
    UART_READY = 1'b1;
    drain("ovf_drain");
    min_gap = 1000;
    for (int i = r0 + 1; i < got_q.size(); i++)
      if (stamp_q[i] - stamp_q[i - 1] < min_gap) min_gap = stamp_q[i] - stamp_q[i - 1];
    check("ovf_min_gap", 32'(min_gap), 3);
    check("ovf_sticky", 32'(OVERFLOW), 1);

    // Reset during a strobe with bytes queued.
    UART_READY = 1'b0;
    step();
    for (int i = 0; i < 5; i++) shift_byte(8'($urandom));
    UART_READY = 1'b1;
    budget = 50;
    while (!TX_VALID && budget > 0) begin
      step();
      budget--;
    end
    check("mid_strobe_seen", 32'(TX_VALID), 1);
    RESET = 1'b1;
    #1;
    check("mid_rst_tx_valid", 32'(TX_VALID), 0);
    exp_q.delete();
    pend_bits.delete();
    run_xor = 8'h00;
    n_seen = got_q.size();
    step(); step();
    RESET = 1'b0;
    step();
    check("mid_rst_bytes_sent", 32'(BYTES_SENT), 0);
    check("mid_rst_overflow", 32'(OVERFLOW), 0);
    check("mid_rst_busy", 32'(BUSY), 0);
    check("mid_rst_tx_data", 32'(TX_DATA), 0);
    repeat (30) step();
    check("mid_rst_no_strobe", got_q.size() - n_seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
